adder_arbiter_2ch: RTL and testbench
====================================

ADDER_ARBITER_2CH -- requirements
Module: adder_arbiter_2ch

Interface
REQ-001 Parameter: WIDTH, default 16, operand width; the sum is WIDTH+1 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  channel request; held high with its operands stable until granted.
REQ-005 a0, b0, a1, b1  input  WIDTH each  channel operands.
REQ-006 grant0, grant1  output  1 each  combinational; an operand transfer occurs on a cycle where reqN and grantN are both high.
REQ-007 res_valid  output  1  registered result-valid flag.
REQ-008 res_id  output  1  registered channel tag of the result (0 or 1).
REQ-009 res_sum  output  WIDTH+1  registered result a+b, carry-in 0, carry in the MSB.
REQ-010 res_ready  input  1  consumer accept; a result transfers on a cycle where res_valid and res_ready are both high.

Function
REQ-011 Two-stage pipeline:
  - Operand stage: op_valid, op_id, op_a, op_b.
  - Result stage: res_valid, res_id, res_sum, registered inside the adder sub-module.
REQ-012 Stall logic:
  - out_free = !res_valid | res_ready.
  - op_adv = op_valid & out_free.
  - in_free = !op_valid | op_adv.
REQ-013 grant0 and grant1 are both 0 whenever in_free=0 or reset=1.
REQ-014 At most one grant is high per cycle, and a grant is only ever asserted to a requesting channel.
REQ-015 Round-robin arbitration:
  - The register last_id holds the last granted channel.
  - When both channels request, the channel != last_id is granted.
  - When only one channel requests, that channel is granted.
REQ-016 last_id updates to the granted channel on every transfer and holds otherwise.
REQ-017 On a transfer, op_valid<=1, op_id<=channel and op_a/op_b<=that channel's operands at the same edge.
REQ-018 Operand stage update:
  - On op_adv without a new transfer, op_valid<=0.
  - With no op_adv and no transfer, the operand stage holds.
REQ-019 On op_adv, res_valid<=1, res_id<=op_id and res_sum<=op_a+op_b (WIDTH+1-bit, no truncation).
REQ-020 On res_valid & res_ready without op_adv, res_valid<=0.
REQ-021 While res_valid=1 and res_ready=0, res_valid, res_id and res_sum hold bit-stable.
REQ-022 Latency: a transfer at edge E gives res_valid=1 after edge E+1 when unstalled.
REQ-023 Throughput: one result per cycle under continuous requests with res_ready=1.
REQ-024 Simultaneous events: a transfer, op_adv and a result accept in the same cycle all take effect, with no bubble and no loss.
REQ-025 Overflow: 0xFFFF+0xFFFF gives 0x1FFFE; no wrap beyond WIDTH+1 bits.

Reset
REQ-026 On reset=1 at an edge, the following clear:
  - op_valid=0, res_valid=0;
  - res_id=0, res_sum=0;
  - op_a=0, op_b=0, op_id=0;
  - last_id=1, so channel 0 wins the first tie.
REQ-027 Reset mid-operation discards all in-flight operands; no result for them ever appears.
REQ-028 No grant is issued in a cycle where reset=1.

Structure
REQ-029 The shared package holds:
  - the WIDTH default (16);
  - channel-ID constants CH0=0, CH1=1;
  - the reset value of last_id (1).
REQ-030 One sub-module, adder_16bit_reg:
  - ports clk, reset, en, a, b, c_in (tied 0), sum[WIDTH:0];
  - sum is registered and captured when en=1;
  - it is instantiated once, with en=op_adv.
REQ-031 The arbiter, operand stage and res_valid/res_id registers live in adder_arbiter_2ch.

Verification
REQ-032 Single request:
  - Stimulus: req0=1, a0=0x1234, b0=0x0001, res_ready=1.
  - Response: grant0=1 in the same cycle; one cycle after the transfer edge, res_valid=1, res_id=0, res_sum=0x01235.
REQ-033 Carry out:
  - Stimulus: req1 with a1=0xFFFF, b1=0xFFFF.
  - Response: res_id=1, res_sum=0x1FFFE.
REQ-034 Contention:
  - Stimulus: req0=req1=1 continuously after reset, res_ready=1, 8 cycles.
  - Response: grants alternate 0,1,0,1,...; 8 results in 8 consecutive cycles; ids alternate starting at 0.
REQ-035 Backpressure:
  - Stimulus: res_ready=0 for 3 cycles with both channels requesting.
  - Response: res_* held stable; exactly one further grant fills the operand stage, then no grant until res_ready=1; no result lost or duplicated.
REQ-036 Reset mid-operation:
  - Stimulus: reset=1 for 1 cycle with both stages valid.
  - Response: res_valid=0 next cycle; the dropped operands never appear; the next tie grants channel 0.
REQ-037 Random traffic:
  - Stimulus: 100 random operand pairs, random req and res_ready.
  - Response: every res_sum equals a+b of the matching channel transfer, in grant order; error count 0.

Source files
------------

// File: rtl/adder_arbiter_2ch_pkg.sv
// Shared constants for the two-channel arbitrated adder.
package adder_arbiter_2ch_pkg;

  // Default operand width; results carry one extra bit
  localparam int unsigned WIDTH_DEF = 16;

  // Channel identifiers, also used as the result tag
  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } ch_id_t;

  // Reset value of the round-robin pointer: pointing at CH1 lets CH0 win the first tie
  localparam ch_id_t LAST_ID_RST = CH1;

endpackage

// File: rtl/adder_16bit_reg.sv
// Registered adder: captures a+b+c_in into a WIDTH+1 bit sum when enabled.
module adder_16bit_reg
  import adder_arbiter_2ch_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] sum_next;

  // Full-width add so the carry lands in the MSB
  always_comb begin
    sum_next = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
  end

  // Result register; holds while not enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum_next;
    end
  end

endmodule

// File: rtl/adder_arbiter_2ch.sv
// Two-channel round-robin arbiter feeding a two-stage add pipeline
// (operand stage, then registered result stage with valid/ready).
module adder_arbiter_2ch
  import adder_arbiter_2ch_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             grant0,
  output logic             grant1,
  output logic             res_valid,
  output logic             res_id,
  output logic [WIDTH:0]   res_sum,
  input  logic             res_ready
);

  logic             op_valid;
  ch_id_t           op_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  ch_id_t           last_id;

  logic   out_free;
  logic   op_adv;
  logic   in_free;
  logic   xfer;
  ch_id_t xfer_id;

  // Stall chain and round-robin grant; no grant while reset is asserted
  always_comb begin
    out_free = !res_valid || res_ready;
    op_adv   = op_valid && out_free;
    in_free  = !op_valid || op_adv;
    grant0   = 1'b0;
    grant1   = 1'b0;
    if (!reset && in_free) begin
      if (req0 && req1) begin
        grant0 = (last_id == CH1);
        grant1 = (last_id == CH0);
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
    xfer    = grant0 || grant1;
    xfer_id = grant1 ? CH1 : CH0;
  end

  // Operand stage and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      op_valid <= 1'b0;
      op_id    <= CH0;
      op_a     <= '0;
      op_b     <= '0;
      last_id  <= LAST_ID_RST;
    end else if (xfer) begin
      op_valid <= 1'b1;
      op_id    <= xfer_id;
      op_a     <= grant1 ? a1 : a0;
      op_b     <= grant1 ? b1 : b0;
      last_id  <= xfer_id;
    end else if (op_adv) begin
      op_valid <= 1'b0;
    end
  end

  // Result valid/tag; the sum itself is registered inside the adder
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_id    <= 1'b0;
    end else if (op_adv) begin
      res_valid <= 1'b1;
      res_id    <= op_id;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  adder_16bit_reg #(
    .WIDTH (WIDTH)
  ) u_add (
    .clk   (clk),
    .reset (reset),
    .en    (op_adv),
    .a     (op_a),
    .b     (op_b),
    .c_in  (1'b0),
    .sum   (res_sum)
  );

endmodule

// File: tb/tb_adder_arbiter_2ch.sv
// Self-checking bench for adder_arbiter_2ch: directed scenarios plus random
// traffic checked against an in-order queue model of the pipeline.
module tb_adder_arbiter_2ch;

  localparam int unsigned W = 16;

  logic         clk;
  logic         reset;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         grant0, grant1;
  logic         res_valid;
  logic         res_id;
  logic [W:0]   res_sum;
  logic         res_ready;

  adder_arbiter_2ch #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .grant0    (grant0),
    .grant1    (grant1),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .res_ready (res_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: every transfer enters an in-order queue; the head is visible as
  // the result once it has moved into the result slot (res_full).
  typedef struct {
    bit         id;
    logic [W:0] sum;
  } item_t;

  item_t       pipe[$];
  bit          res_full = 1'b0;
  bit          m_last   = 1'b1;
  bit          last_g0, last_g1;
  int unsigned n_xfer = 0;
  int unsigned n_acc  = 0;

  // Check outputs for the current inputs, then advance one clock and the model
  task automatic step();
    bit    op_occ, out_free, op_adv, in_free, g0, g1;
    item_t it;
    #1;
    op_occ   = (pipe.size() > (res_full ? 1 : 0));
    out_free = !res_full || res_ready;
    op_adv   = op_occ && out_free;
    in_free  = !op_occ || op_adv;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!reset && in_free) begin
      if (req0 && req1) begin
        if (m_last) g0 = 1'b1; else g1 = 1'b1;
      end else if (req0) g0 = 1'b1;
      else if (req1) g1 = 1'b1;
    end
    check_eq("grant0", 32'(grant0), 32'(g0));
    check_eq("grant1", 32'(grant1), 32'(g1));
    check_eq("res_valid", 32'(res_valid), 32'(res_full));
    if (res_full) begin
      check_eq("res_id", 32'(res_id), 32'(pipe[0].id));
      check_eq("res_sum", 32'(res_sum), 32'(pipe[0].sum));
    end
    @(posedge clk);
    if (reset) begin
      pipe.delete();
      res_full = 1'b0;
      m_last   = 1'b1;
    end else begin
      if (res_full && res_ready) begin
        void'(pipe.pop_front());
        res_full = 1'b0;
        n_acc++;
      end
      if (op_adv) res_full = 1'b1;
      if (g0 || g1) begin
        it.id  = g1;
        it.sum = g1 ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
        pipe.push_back(it);
        m_last = g1;
        n_xfer++;
      end
    end
    last_g0 = g0;
    last_g1 = g1;
    #1;
  endtask

  int unsigned base;
  int unsigned budget;

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; res_ready = 1'b1;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    @(posedge clk);
    #1;
    step();
    step();

    // Reset state
    reset = 1'b0;
    #1;
    check_eq("rst_res_valid", 32'(res_valid), 32'd0);
    check_eq("rst_res_id", 32'(res_id), 32'd0);
    check_eq("rst_res_sum", 32'(res_sum), 32'd0);

    // Single request on channel 0
    req0 = 1'b1; a0 = 16'h1234; b0 = 16'h0001;
    step();
    req0 = 1'b0;
    step();
    check_eq("single_valid", 32'(res_valid), 32'd1);
    check_eq("single_id", 32'(res_id), 32'd0);
    check_eq("single_sum", 32'(res_sum), 32'h01235);
    step();

    // Carry out on channel 1
    req1 = 1'b1; a1 = 16'hFFFF; b1 = 16'hFFFF;
    step();
    req1 = 1'b0;
    step();
    check_eq("carry_id", 32'(res_id), 32'd1);
    check_eq("carry_sum", 32'(res_sum), 32'h1FFFE);
    step();

    // Contention from reset: alternation starting at channel 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    base = n_acc;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("contend_alt", 32'(last_g1), 32'(i % 2));
      if (last_g0) begin a0 = 16'($urandom); b0 = 16'($urandom); end
      if (last_g1) begin a1 = 16'($urandom); b1 = 16'($urandom); end
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    step();
    check_eq("contend_results", n_acc - base, 32'd8);

    // Backpressure from an empty pipe: two grants fill both stages, then none
    base = n_xfer;
    res_ready = 1'b0; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (last_g0) begin a0 = 16'($urandom); b0 = 16'($urandom); end
      if (last_g1) begin a1 = 16'($urandom); b1 = 16'($urandom); end
    end
    check_eq("bp_grants", n_xfer - base, 32'd2);

    // Reset with both stages full: everything in flight is dropped
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("midrst_valid", 32'(res_valid), 32'd0);
    res_ready = 1'b1;
    step();
    check_eq("midrst_tie_ch0", 32'(last_g0), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    step();
    step();

    // Random traffic: 100 transfers, requests held until granted
    base   = n_xfer;
    budget = 0;
    while ((n_xfer - base) < 100 && budget < 3000) begin
      if (!req0 || last_g0) begin
        req0 = 1'($urandom); a0 = 16'($urandom); b0 = 16'($urandom);
      end
      if (!req1 || last_g1) begin
        req1 = 1'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
      end
      res_ready = ($urandom_range(0, 3) != 0);
      last_g0 = 1'b0;
      last_g1 = 1'b0;
      step();
      budget++;
    end
    if ((n_xfer - base) < 100)
      check_eq("random_budget", n_xfer - base, 32'd100);
    req0 = 1'b0; req1 = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_eq("drain_empty", 32'(pipe.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
